// File: rtl/apb_master_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_master_bridge_pkg
// Shared definitions for the APB master bridge:
//   - FSM state encodings (2 bits, IDLE/SETUP/ACCESS/RESP)
//   - default bus widths and watchdog depth
//   - helper to size the watchdog counter
// ----------------------------------------------------------------------------
package apb_master_bridge_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_BUS_WIDTH      = 64;
    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int unsigned wd_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_watchdog.sv
// ----------------------------------------------------------------------------
// apb_watchdog_counter
// Counts ACCESS cycles spent waiting on the slave.
//   clk_i      in  clock
//   rst_ni     in  async active-low reset
//   clear_i    in  zero the count (held during SETUP)
//   enable_i   in  count this cycle (ACCESS)
//   expired_o  out current enabled cycle is the TIMEOUT_CYCLES-th one
// ----------------------------------------------------------------------------
module apb_watchdog_counter
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = wd_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flag one cycle early so the FSM leaves ACCESS after exactly
    // TIMEOUT_CYCLES cycles without a pready.
    assign expired_o = enable_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
// Converts single host requests (valid/ready) into APB SETUP/ACCESS transfers
// and returns read data / error status on a held response channel. A watchdog
// aborts transfers whose slave never asserts pready. One transfer in flight.
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   req_valid_i/req_ready_o               host request handshake
//   req_write_i, req_addr_i,
//   req_wdata_i, req_strb_i               request payload
//   rsp_valid_o/rsp_ready_i               response handshake
//   rsp_rdata_o, rsp_err_o, rsp_timeout_o response payload
//   psel_o, penable_o, pwrite_o, paddr_o,
//   pwdata_o, pstrb_o                     APB request side
//   pready_i, pslverr_i, prdata_i         APB completion side
//   busy_o                                high whenever not IDLE
// All outputs are registered.
// ----------------------------------------------------------------------------
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [BUS_WIDTH-1:0]   req_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] req_strb_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   rsp_timeout_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [ADDR_WIDTH-1:0]  paddr_o,
    output logic [BUS_WIDTH-1:0]   pwdata_o,
    output logic [BUS_WIDTH/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic                   pslverr_i,
    input  logic [BUS_WIDTH-1:0]   prdata_i,
    output logic                   busy_o
);

    // Elaboration-time sanity on the parameter set.
    if ((BUS_WIDTH % DATA_WIDTH) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("apb_master_bridge: illegal parameter combination");
    end

    logic [1:0] state_q;
    logic       wd_clear;
    logic       wd_en;
    logic       wd_expired;

    assign wd_clear = (state_q == ST_SETUP);
    assign wd_en    = (state_q == ST_ACCESS);

    apb_watchdog_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (wd_clear),
        .enable_i  (wd_en),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            busy_o        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        // Reads never carry strobes or write data on the bus.
                        paddr_o     <= req_addr_i;
                        pwrite_o    <= req_write_i;
                        pwdata_o    <= req_write_i ? req_wdata_i : '0;
                        pstrb_o     <= req_write_i ? req_strb_i  : '0;
                        psel_o      <= 1'b1;
                        penable_o   <= 1'b0;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_o <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= pslverr_i;
                        rsp_rdata_o <= (pwrite_o || pslverr_i) ? '0 : prdata_i;
                        state_q     <= ST_RESP;
                    end else if (wd_expired) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_rdata_o   <= '0;
                        state_q       <= ST_RESP;
                    end
                end
                default: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o   <= 1'b0;
                        rsp_err_o     <= 1'b0;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= '0;
                        req_ready_o   <= 1'b1;
                        busy_o        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed and randomized transfers against a transaction-level model of the
// bridge: the slave answers after a chosen number of wait cycles, and the
// expected response follows from that delay, the error flag and direction.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [63:0] req_wdata_i = '0;
    logic [7:0]  req_strb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [63:0] pwdata_o;
    logic [7:0]  pstrb_o;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;
    logic [63:0] prdata_i = '0;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    apb_master_bridge #(
        .DATA_WIDTH     (32),
        .BUS_WIDTH      (64),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_strb_i    (req_strb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i),
        .prdata_i      (prdata_i),
        .busy_o        (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // delay = number of ACCESS cycles with pready low before the slave answers;
    // delay >= TO means the slave never answers inside the watchdog window.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                           input logic [7:0] st, input int delay, input bit serr,
                           input logic [63:0] rd, input int rsp_wait);
        bit          exp_to;
        bit          exp_err;
        int          n_acc;
        int          guard;
        logic [63:0] exp_rd;

        exp_to  = (delay >= TO);
        n_acc   = exp_to ? TO : delay + 1;
        exp_err = exp_to || serr;
        exp_rd  = (wr || exp_err) ? 64'd0 : rd;

        guard = 0;
        while (req_ready_o !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        chk("req_ready_idle", req_ready_o, 1);

        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_strb_i  = st;
        step();
        // Scramble the request bus: the bridge must have latched it.
        req_valid_i = 1'b0;
        req_addr_i  = $urandom();
        req_wdata_i = rnd64();
        req_strb_i  = 8'($urandom());
        chk("setup_psel", psel_o, 1);
        chk("setup_penable", penable_o, 0);
        chk("setup_busy", busy_o, 1);
        chk("setup_req_ready", req_ready_o, 0);

        // A pready during SETUP must not complete the transfer.
        pready_i  = 1'b1;
        pslverr_i = 1'b1;
        prdata_i  = rnd64();
        step();

        for (int k = 1; k <= n_acc; k++) begin
            chk("access_psel", psel_o, 1);
            chk("access_penable", penable_o, 1);
            chk("access_pwrite", pwrite_o, wr);
            chk("access_paddr", paddr_o, addr);
            chk("access_pwdata", pwdata_o, wr ? wd : 64'd0);
            chk("access_pstrb", pstrb_o, wr ? st : 8'd0);
            chk("access_rsp_valid", rsp_valid_o, 0);
            if (k == delay + 1) begin
                pready_i  = 1'b1;
                pslverr_i = serr;
                prdata_i  = rd;
            end else begin
                pready_i  = 1'b0;
                pslverr_i = 1'($urandom());
                prdata_i  = rnd64();
            end
            step();
        end

        // Stale completion inputs during RESP must be ignored.
        pready_i  = 1'b1;
        pslverr_i = 1'b1;
        prdata_i  = rnd64();
        chk("resp_valid", rsp_valid_o, 1);
        chk("resp_psel", psel_o, 0);
        chk("resp_penable", penable_o, 0);
        chk("resp_err", rsp_err_o, exp_err);
        chk("resp_timeout", rsp_timeout_o, exp_to);
        chk("resp_rdata", rsp_rdata_o, exp_rd);
        chk("resp_busy", busy_o, 1);

        for (int i = 0; i < rsp_wait; i++) begin
            step();
            chk("hold_valid", rsp_valid_o, 1);
            chk("hold_req_ready", req_ready_o, 0);
            chk("hold_psel", psel_o, 0);
            chk("hold_rdata", rsp_rdata_o, exp_rd);
        end

        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        chk("done_valid", rsp_valid_o, 0);
        chk("done_req_ready", req_ready_o, 1);
        chk("done_busy", busy_o, 0);
        chk("done_err", rsp_err_o, 0);
        chk("done_timeout", rsp_timeout_o, 0);
        chk("done_psel", psel_o, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pstrb", pstrb_o, 0);
        rst_ni = 1'b1;
        step();

        // Stale pready and rsp_ready in IDLE do nothing.
        pready_i    = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (2) step();
        chk("idle_stale_psel", psel_o, 0);
        chk("idle_stale_valid", rsp_valid_o, 0);
        chk("idle_stale_ready", req_ready_o, 1);
        pready_i    = 1'b0;
        rsp_ready_i = 1'b0;

        // Directed cases
        run_txn(1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0, 64'h0, 0);
        run_txn(1'b0, 32'h10, 64'h0, 8'hFF, 0, 1'b0, 64'h1234, 0);
        run_txn(1'b0, 32'h20, 64'h0, 8'h0F, TO + 5, 1'b0, 64'h5555, 0);
        run_txn(1'b0, 32'h30, 64'h0, 8'h00, 2, 1'b1, 64'hABCD, 0);
        run_txn(1'b1, 32'h40, 64'h0123_4567_89AB_CDEF, 8'h3C, 1, 1'b0, 64'h0, 5);
        run_txn(1'b0, 32'h44, 64'h0, 8'h00, TO - 1, 1'b0, 64'h7777_0000_1111, 1);

        // Reset in the middle of ACCESS
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h80;
        req_wdata_i = 64'h1;
        req_strb_i  = 8'h01;
        step();
        req_valid_i = 1'b0;
        step();
        chk("pre_rst_penable", penable_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_psel", psel_o, 0);
        chk("async_rst_penable", penable_o, 0);
        chk("async_rst_busy", busy_o, 0);
        #3;
        rst_ni = 1'b1;
        step();
        chk("post_rst_req_ready", req_ready_o, 1);
        chk("post_rst_rsp_valid", rsp_valid_o, 0);
        chk("post_rst_psel", psel_o, 0);

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            bit          wr;
            int          dly;
            bit          serr;
            int          wt;
            wr   = 1'($urandom_range(0, 1));
            dly  = ($urandom_range(0, 9) < 2) ? TO + int'($urandom_range(0, 4))
                                              : int'($urandom_range(0, 6));
            serr = ($urandom_range(0, 3) == 0);
            wt   = int'($urandom_range(0, 3));
            run_txn(wr, $urandom(), rnd64(), 8'($urandom()), dly, serr, rnd64(), wt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
